// File: rtl/r_burst_arbiter_pkg.sv
// r_arb_pkg: shared state type, default sizes and width helpers
// for the read-side burst arbiter.
package r_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } r_arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_STALL_MAX  = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter able to hold 0..max.
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/r_burst_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// req/ptr in -> one-hot win (ptr index highest priority), any.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          any
);

  logic [N-1:0] rot;
  logic [N-1:0] pick;

  // Rotate so ptr lands on bit 0, take the lowest set bit,
  // then rotate the single hit back to its real position.
  assign rot  = N'({req, req} >> ptr);
  assign pick = rot & (~rot + N'(1));
  assign win  = N'(({pick, pick} << ptr) >> N);
  assign any  = |req;

endmodule

// File: rtl/r_burst_arbiter.sv
// r_burst_arbiter: shares the FIFO read port among NUM_REQ consumers.
// Ports: clk_r_i/rst_r_i (sync, active-high), r_empty_i/r_data_i/r_en_o
// to the FIFO; req_i/rdy_i in, gnt_o/valid_o/data_o/last_o out.
module r_burst_arbiter
  import r_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int STALL_MAX  = DEF_STALL_MAX
) (
  input  logic                  clk_r_i,
  input  logic                  rst_r_i,
  input  logic                  r_empty_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  r_en_o,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    rdy_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  localparam int PW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(BURST_LEN);
  localparam int SW = cnt_w(STALL_MAX);

  localparam logic [CW-1:0] CNT_LAST   = CW'(BURST_LEN - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_REQ - 1);

  r_arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] win;
  logic [NUM_REQ-1:0] valid;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      own, ptr_nxt;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      stall_q, stall_d;

  logic any;
  logic busy;
  logic xfer;
  logic last;
  logic req_own;
  logic stall_hit;
  logic done;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (req_i),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Outputs are masked while reset is held so no word is popped
  // in the reset cycle itself.
  assign busy  = (state_q == BURST) && !rst_r_i;
  assign valid = (busy && !r_empty_i) ? gnt_q : '0;

  // Masking with the grant keeps the other consumers' req/rdy
  // bits out of every decision taken during a burst.
  assign xfer      = |(valid & rdy_i);
  assign last      = xfer && (cnt_q == CNT_LAST);
  assign req_own   = |(gnt_q & req_i);
  assign stall_hit = r_empty_i && (stall_q == STALL_LAST);
  assign done      = last || (!xfer && !req_own) || stall_hit;

  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) own = PW'(i);
    end
  end

  assign ptr_nxt = (own == PTR_LAST) ? '0 : own + PW'(1);

  always_ff @(posedge clk_r_i) begin
    if (rst_r_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    unique case (state_q)
      IDLE: begin
        if (any && !r_empty_i) begin
          state_d = BURST;
          gnt_d   = win;
          cnt_d   = '0;
          stall_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          cnt_d   = cnt_q + CW'(1);
          stall_d = '0;
        end else if (r_empty_i) begin
          stall_d = stall_q + SW'(1);
        end
        // A not-ready consumer facing data leaves stall as is.
        if (done) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          cnt_d   = '0;
          stall_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o   = gnt_q;
  assign valid_o = valid;
  assign r_en_o  = xfer;
  assign last_o  = last;
  assign data_o  = r_data_i;

endmodule

// File: tb/tb_r_burst_arbiter.sv
// tb_r_burst_arbiter: queue-based FIFO, transaction-level arbiter
// model, scenario tasks and a randomized soak.
module tb_r_burst_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_empty;
  logic [DW-1:0] r_data;
  logic          r_en;
  logic [N-1:0]  req;
  logic [N-1:0]  rdy;
  logic [N-1:0]  gnt;
  logic [N-1:0]  valid;
  logic [DW-1:0] data;
  logic          last;

  r_burst_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .STALL_MAX  (SM)
  ) dut (
    .clk_r_i   (clk),
    .rst_r_i   (rst),
    .r_empty_i (r_empty),
    .r_data_i  (r_data),
    .r_en_o    (r_en),
    .req_i     (req),
    .rdy_i     (rdy),
    .gnt_o     (gnt),
    .valid_o   (valid),
    .data_o    (data),
    .last_o    (last)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo[$];
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] rx_q[$];
  bit            force_empty;
  bit            pop_pend;

  int  grant_q[$];
  int  gcyc_q[$];
  int  wlen_q[$];
  int  dur_q[$];
  byte reason_q[$];
  int  pops[N];
  int  lasts;
  int  cyc;

  // Model: owner index (-1 idle), next-start pointer, words left
  // in the burst, run of empty cycles, burst bookkeeping.
  int  m_owner = -1;
  int  m_ptr   = 0;
  int  m_left  = BL;
  int  m_streak;
  int  m_dur;
  int  m_words;
  byte why;

  logic [N-1:0] eg, ev;
  logic         er, el;

  always @(negedge clk) begin
    cyc++;
    eg = '0;
    ev = '0;
    er = 1'b0;
    el = 1'b0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (!rst && m_owner >= 0) begin
      ev[m_owner] = !r_empty;
      er = !r_empty && rdy[m_owner];
      el = er && (m_left == 1);
    end
    total += 4;
    if (gnt !== eg) begin
      bad++;
      $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt, eg);
    end
    if (valid !== ev) begin
      bad++;
      $display("FAIL valid cyc=%0d got=%b want=%b", cyc, valid, ev);
    end
    if (r_en !== er) begin
      bad++;
      $display("FAIL r_en cyc=%0d got=%b want=%b", cyc, r_en, er);
    end
    if (last !== el) begin
      bad++;
      $display("FAIL last cyc=%0d got=%b want=%b", cyc, last, el);
    end
    total++;
    if (r_en === 1'b1 && r_empty) begin
      bad++;
      $display("FAIL underflow cyc=%0d got r_en=1 want 0", cyc);
    end
    total++;
    if (!$onehot0(gnt)) begin
      bad++;
      $display("FAIL onehot cyc=%0d got=%b want onehot0", cyc, gnt);
    end
    if (r_en === 1'b1) begin
      total++;
      if (fifo.size() == 0 || data !== fifo[0]) begin
        bad++;
        $display("FAIL data cyc=%0d got=%h want=%h", cyc, data,
                 (fifo.size() > 0) ? fifo[0] : '0);
      end
      rx_q.push_back(data);
      for (int k = 0; k < N; k++) if (gnt[k]) pops[k]++;
    end
    if (last === 1'b1) lasts++;
    pop_pend = (r_en === 1'b1);

    if (rst) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_left   = BL;
      m_streak = 0;
    end else if (m_owner < 0) begin
      if (req != '0 && !r_empty) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_left   = BL;
        m_streak = 0;
        m_dur    = 0;
        m_words  = 0;
        grant_q.push_back(m_owner);
        gcyc_q.push_back(cyc + 1);
      end
    end else begin
      m_dur++;
      if (er) begin
        m_left--;
        m_words++;
        m_streak = 0;
      end else if (r_empty) begin
        m_streak++;
      end
      why = 0;
      if (el) why = "L";
      else if (!er && !req[m_owner]) why = "R";
      else if (m_streak == SM) why = "S";
      if (why != 0) begin
        reason_q.push_back(why);
        wlen_q.push_back(m_words);
        dur_q.push_back(m_dur);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  task automatic fifo_drive();
    r_empty = force_empty || (fifo.size() == 0);
    r_data  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    pop_pend = 1'b0;
    fifo_drive();
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      fifo.push_back(w);
      sent_q.push_back(w);
    end
    fifo_drive();
  endtask

  task automatic clear_logs();
    grant_q.delete();
    gcyc_q.delete();
    wlen_q.delete();
    dur_q.delete();
    reason_q.delete();
    rx_q.delete();
    foreach (pops[k]) pops[k] = 0;
    lasts = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rdy = '0;
    force_empty = 1'b0;
    fifo.delete();
    sent_q.delete();
    fifo_drive();
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    rdy = '1;
    push_words(3);
    tick();
    tick();
    total++;
    if (gnt !== '0 || valid !== '0 || r_en !== 1'b0 || last !== 1'b0) begin
      bad++;
      $display("FAIL reset got gnt=%b valid=%b r_en=%b last=%b want 0",
               gnt, valid, r_en, last);
    end
    do_reset();
    total++;
    if (gnt !== '0 || valid !== '0) begin
      bad++;
      $display("FAIL reset_idle got gnt=%b valid=%b want 0", gnt, valid);
    end
  endtask

  task automatic test_single();
    int i;
    do_reset();
    push_words(6);
    req = 4'b0001;
    rdy = '1;
    i = 0;
    while (reason_q.size() < 2 && i < 40) begin
      tick();
      i++;
    end
    total++;
    if (reason_q.size() < 2) begin
      bad++;
      $display("FAIL single_timeout got bursts=%0d want 2", reason_q.size());
    end else begin
      total++;
      if (grant_q[0] != 0 || grant_q[1] != 0) begin
        bad++;
        $display("FAIL single_gnt got %0d,%0d want 0,0", grant_q[0], grant_q[1]);
      end
      total++;
      if (wlen_q[0] != 4 || wlen_q[1] != 2) begin
        bad++;
        $display("FAIL single_len got %0d,%0d want 4,2", wlen_q[0], wlen_q[1]);
      end
      total++;
      if (gcyc_q[1] - gcyc_q[0] != BL + 1) begin
        bad++;
        $display("FAIL single_gap got %0d want %0d", gcyc_q[1] - gcyc_q[0], BL + 1);
      end
      total++;
      if (lasts != 1) begin
        bad++;
        $display("FAIL single_last got %0d want 1", lasts);
      end
    end
    total++;
    if (rx_q.size() != 6 || rx_q != sent_q) begin
      bad++;
      $display("FAIL single_order got n=%0d want n=6 in order", rx_q.size());
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int i;
    do_reset();
    push_words(40);
    req = '1;
    rdy = '1;
    i = 0;
    while (wlen_q.size() < 5 && i < 60) begin
      tick();
      i++;
    end
    total++;
    if (wlen_q.size() < 5) begin
      bad++;
      $display("FAIL rr_timeout got bursts=%0d want 5", wlen_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (grant_q[k] != k % N || wlen_q[k] != BL) begin
          bad++;
          $display("FAIL rr_order k=%0d got gnt=%0d len=%0d want gnt=%0d len=%0d",
                   k, grant_q[k], wlen_q[k], k % N, BL);
        end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_rdy_toggle();
    int i;
    bit tog;
    do_reset();
    push_words(10);
    req = 4'b0100;
    rdy = '1;
    tog = 1'b1;
    i = 0;
    while (reason_q.size() < 1 && i < 40) begin
      tick();
      rdy = N'($urandom);
      rdy[2] = tog;
      tog = ~tog;
      i++;
    end
    total++;
    if (reason_q.size() < 1) begin
      bad++;
      $display("FAIL rdy_timeout got bursts=0 want 1");
    end else begin
      total++;
      if (grant_q[0] != 2 || wlen_q[0] != BL || reason_q[0] != "L") begin
        bad++;
        $display("FAIL rdy_burst got gnt=%0d len=%0d why=%c want 2,%0d,L",
                 grant_q[0], wlen_q[0], reason_q[0], BL);
      end
      total++;
      if (dur_q[0] < 2 * BL - 1) begin
        bad++;
        $display("FAIL rdy_dur got %0d want >=%0d", dur_q[0], 2 * BL - 1);
      end
    end
    req = '0;
    rdy = '1;
    tick();
  endtask

  task automatic test_stall();
    int i;
    do_reset();
    push_words(1);
    req = 4'b0010;
    rdy = '1;
    i = 0;
    while (reason_q.size() < 1 && i < 30) begin
      tick();
      i++;
    end
    total++;
    if (reason_q.size() < 1) begin
      bad++;
      $display("FAIL stall_timeout got bursts=0 want 1");
    end else begin
      total++;
      if (grant_q[0] != 1 || wlen_q[0] != 1 || reason_q[0] != "S"
          || dur_q[0] != SM + 1) begin
        bad++;
        $display("FAIL stall_rel got gnt=%0d len=%0d why=%c dur=%0d want 1,1,S,%0d",
                 grant_q[0], wlen_q[0], reason_q[0], dur_q[0], SM + 1);
      end
    end
    push_words(4);
    req = '1;
    i = 0;
    while (grant_q.size() < 2 && i < 10) begin
      tick();
      i++;
    end
    total++;
    if (grant_q.size() < 2 || grant_q[1] != 2) begin
      bad++;
      $display("FAIL stall_ptr got n=%0d gnt=%0d want 2", grant_q.size(),
               (grant_q.size() > 1) ? grant_q[1] : -1);
    end
    req = '0;
    tick();
  endtask

  task automatic test_req_drop();
    int i;
    do_reset();
    push_words(8);
    req = 4'b1000;
    rdy = '1;
    i = 0;
    while (pops[3] < 2 && i < 20) begin
      tick();
      i++;
    end
    req = '0;
    rdy = '0;
    i = 0;
    while (reason_q.size() < 1 && i < 10) begin
      tick();
      i++;
    end
    total++;
    if (reason_q.size() < 1 || wlen_q[0] != 2 || reason_q[0] != "R") begin
      bad++;
      $display("FAIL drop_rel got n=%0d len=%0d want len=2 why=R", reason_q.size(),
               (wlen_q.size() > 0) ? wlen_q[0] : -1);
    end
    rdy = '1;
    req = 4'b1001;
    i = 0;
    while (grant_q.size() < 2 && i < 10) begin
      tick();
      i++;
    end
    total++;
    if (grant_q.size() < 2 || grant_q[1] != 0) begin
      bad++;
      $display("FAIL drop_next got n=%0d gnt=%0d want 0", grant_q.size(),
               (grant_q.size() > 1) ? grant_q[1] : -1);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int i;
    do_reset();
    push_words(8);
    req = 4'b0100;
    rdy = '1;
    i = 0;
    while (pops[2] < 1 && i < 10) begin
      tick();
      i++;
    end
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    total++;
    if (gnt !== '0 || valid !== '0 || r_en !== 1'b0 || last !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got gnt=%b valid=%b r_en=%b last=%b want 0",
               gnt, valid, r_en, last);
    end
    req = '1;
    i = 0;
    while (grant_q.size() < 2 && i < 10) begin
      tick();
      i++;
    end
    total++;
    if (grant_q.size() < 2 || grant_q[1] != 0) begin
      bad++;
      $display("FAIL mid_next got n=%0d gnt=%0d want 0", grant_q.size(),
               (grant_q.size() > 1) ? grant_q[1] : -1);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req = N'($urandom);
      rdy = N'($urandom | $urandom);
      if ($urandom_range(0, 3) == 0 && fifo.size() < 48)
        push_words($urandom_range(1, 5));
      force_empty = ($urandom_range(0, 15) == 0);
      fifo_drive();
      tick();
    end
    force_empty = 1'b0;
    req = '0;
    fifo_drive();
    tick();
    total++;
    if (grant_q.size() == 0) begin
      bad++;
      $display("FAIL rand_grants got 0 want >0");
    end
    errs = 0;
    for (int i = 0; i < rx_q.size(); i++)
      if (i >= sent_q.size() || rx_q[i] !== sent_q[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rand_order got %0d misordered want 0", errs);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    rdy = '0;
    force_empty = 1'b0;
    pop_pend = 1'b0;
    fifo_drive();
    test_reset();
    test_single();
    test_round_robin();
    test_rdy_toggle();
    test_stall();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
